// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control types.
//   pipe_state_t : per-latch control word used by every inter-stage latch
//   hz_state_t   : hazard controller FSM state
//   hz_dec_t     : per-cycle control decision, listed in priority order
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  typedef enum logic [2:0] {
    DEC_MISS    = 3'd0,  // dcache miss: freeze everything
    DEC_REDIR   = 3'd1,  // apply live or deferred redirect
    DEC_FLUSH   = 3'd2,  // multi-cycle front-end squash
    DEC_LOADUSE = 3'd3,  // one bubble behind a load
    DEC_NOFETCH = 3'd4,  // instruction fetch not complete
    DEC_RUN     = 3'd5   // normal advance
  } hz_dec_t;

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Lowest-index priority matcher for ALU operand forwarding.
//   src  : source register of the operand in EX
//   wsel : destination register per forwarding source, slice i = [i*RW +: RW]
//   wen  : register-write enable per forwarding source
//   sel  : 0 = register file, i+1 = forwarding source i (youngest wins)
module fwd_match #(
  parameter int unsigned NFWD = 2,
  parameter int unsigned RW   = 5
) (
  input  logic [RW-1:0]              src,
  input  logic [NFWD*RW-1:0]         wsel,
  input  logic [NFWD-1:0]            wen,
  output logic [$clog2(NFWD+1)-1:0]  sel
);

  localparam int unsigned SW = $clog2(NFWD + 1);

  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!found && wen[i] && (wsel[i*RW +: RW] == src) && (src != '0)) begin
        sel   = SW'(i + 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller.
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   ihit, dhit          : fetch / data access complete this cycle
//   dREN, dWEN          : MEM-stage load / store pending
//   redirect            : taken branch or jump resolved in EX
//   rs_dec, rt_dec      : ID-stage source registers
//   ex_wsel, ex_is_load : EX-stage destination and load flag
//   rs_ex, rt_ex        : EX-stage source registers
//   fwd_wsel, fwd_wen   : forwarding source destinations / write enables
//   clr_cnt             : synchronous clear of the performance counters
//   latch_state         : pipe_state_t per latch, slice k = [2k +: 2]
//   PC_WEN              : PC update enable
//   fsel_a, fsel_b      : ALU operand forwarding selects
//   stall_cnt, flush_cnt: saturating performance counters
import pipe_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int unsigned NLATCH    = 4,
  parameter int unsigned NFWD      = 2,
  parameter int unsigned RW        = 5,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ihit,
  input  logic                       dhit,
  input  logic                       dREN,
  input  logic                       dWEN,
  input  logic                       redirect,
  input  logic [RW-1:0]              rs_dec,
  input  logic [RW-1:0]              rt_dec,
  input  logic [RW-1:0]              ex_wsel,
  input  logic                       ex_is_load,
  input  logic [RW-1:0]              rs_ex,
  input  logic [RW-1:0]              rt_ex,
  input  logic [NFWD*RW-1:0]         fwd_wsel,
  input  logic [NFWD-1:0]            fwd_wen,
  input  logic                       clr_cnt,
  output logic [2*NLATCH-1:0]        latch_state,
  output logic                       PC_WEN,
  output logic [$clog2(NFWD+1)-1:0]  fsel_a,
  output logic [$clog2(NFWD+1)-1:0]  fsel_b,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int unsigned SW  = $clog2(NFWD + 1);
  localparam int unsigned FLW = $clog2(FLUSH_CYC + 1);
  localparam logic [FLW-1:0]   FL_ONE  = FLW'(1);
  localparam logic [FLW-1:0]   FL_LOAD = FLW'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_t       state, state_nxt;
  logic            redir_pend, redir_pend_nxt;
  logic [FLW-1:0]  flush_left, flush_left_nxt;
  hz_dec_t         dec;
  logic            dmiss;
  logic            load_use;
  logic [SW-1:0]   fsel_a_raw, fsel_b_raw;

  assign dmiss    = (dREN | dWEN) & ~dhit;
  assign load_use = ex_is_load & (ex_wsel != '0) &
                    ((ex_wsel == rs_dec) | (ex_wsel == rt_dec));

  // Single priority-ordered decision shared by next-state and output logic,
  // so both processes always agree on which rule fired.
  always_comb begin
    dec = DEC_RUN;
    if (dmiss)                          dec = DEC_MISS;
    else if (redirect || redir_pend)    dec = DEC_REDIR;
    else if (state == FLUSH)            dec = DEC_FLUSH;
    else if (load_use)                  dec = DEC_LOADUSE;
    else if (!ihit)                     dec = DEC_NOFETCH;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RUN;
      redir_pend <= 1'b0;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      redir_pend <= redir_pend_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    redir_pend_nxt = redir_pend;
    flush_left_nxt = flush_left;
    case (dec)
      DEC_MISS: begin
        state_nxt = DWAIT;
        // Redirect seen while frozen is remembered and applied on dhit.
        if (redirect) redir_pend_nxt = 1'b1;
      end
      DEC_REDIR: begin
        redir_pend_nxt = 1'b0;
        if (FLUSH_CYC > 1) begin
          state_nxt      = FLUSH;
          flush_left_nxt = FL_LOAD;
        end else begin
          state_nxt = RUN;
        end
      end
      DEC_FLUSH: begin
        if (ihit) begin
          if (flush_left <= FL_ONE) begin
            flush_left_nxt = '0;
            state_nxt      = RUN;
          end else begin
            flush_left_nxt = flush_left - FL_ONE;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    latch_state = '0;
    PC_WEN      = 1'b1;
    case (dec)
      DEC_MISS: begin
        for (int unsigned k = 0; k < NLATCH; k++) latch_state[2*k +: 2] = PIPE_STALL;
        PC_WEN = 1'b0;
      end
      DEC_REDIR: begin
        latch_state[1:0] = PIPE_NOP;
        latch_state[3:2] = PIPE_NOP;
      end
      DEC_FLUSH: begin
        latch_state[1:0] = PIPE_NOP;
        PC_WEN           = ihit;
      end
      DEC_LOADUSE: begin
        latch_state[1:0] = PIPE_STALL;
        latch_state[3:2] = PIPE_NOP;
        PC_WEN           = 1'b0;
      end
      DEC_NOFETCH: begin
        latch_state[1:0] = PIPE_NOP;
        PC_WEN           = 1'b0;
      end
      default: ;
    endcase
    if (RST) begin
      for (int unsigned k = 0; k < NLATCH; k++) latch_state[2*k +: 2] = PIPE_NOP;
      PC_WEN = 1'b0;
    end
  end

  // Performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_WEN && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if ((dec == DEC_REDIR) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  // Forwarding selects
  fwd_match #(.NFWD(NFWD), .RW(RW)) u_fwd_a (
    .src  (rs_ex),
    .wsel (fwd_wsel),
    .wen  (fwd_wen),
    .sel  (fsel_a_raw)
  );

  fwd_match #(.NFWD(NFWD), .RW(RW)) u_fwd_b (
    .src  (rt_ex),
    .wsel (fwd_wsel),
    .wen  (fwd_wen),
    .sel  (fsel_b_raw)
  );

  assign fsel_a = RST ? '0 : fsel_a_raw;
  assign fsel_b = RST ? '0 : fsel_b_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus,
// u_a with FLUSH_CYC=1 / CNT_W=8, u_b with FLUSH_CYC=3 / CNT_W=4.
module tb_hazard_ctrl;

  localparam int unsigned NLATCH = 4;
  localparam int unsigned NFWD   = 3;
  localparam int unsigned RW     = 5;

  // latch_state encodings, slice k = bits [2k +: 2]; ENABLE=0 STALL=1 NOP=2
  localparam logic [7:0] ALL_EN  = 8'h00;
  localparam logic [7:0] ALL_ST  = 8'h55;
  localparam logic [7:0] ALL_NOP = 8'hAA;
  localparam logic [7:0] L0_NOP  = 8'h02;
  localparam logic [7:0] L01_NOP = 8'h0A;
  localparam logic [7:0] LD_USE  = 8'h09;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, dREN, dWEN, redirect, ex_is_load, clr_cnt;
  logic [RW-1:0] rs_dec, rt_dec, ex_wsel, rs_ex, rt_ex;
  logic [NFWD*RW-1:0] fwd_wsel;
  logic [NFWD-1:0] fwd_wen;

  logic [2*NLATCH-1:0] ls_a, ls_b;
  logic pc_a, pc_b;
  logic [1:0] fa_a, fb_a, fa_b, fb_b;
  logic [7:0] st_a, fl_a;
  logic [3:0] st_b, fl_b;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.NLATCH(NLATCH), .NFWD(NFWD), .RW(RW), .FLUSH_CYC(1), .CNT_W(8)) u_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .redirect(redirect), .rs_dec(rs_dec), .rt_dec(rt_dec), .ex_wsel(ex_wsel),
    .ex_is_load(ex_is_load), .rs_ex(rs_ex), .rt_ex(rt_ex), .fwd_wsel(fwd_wsel),
    .fwd_wen(fwd_wen), .clr_cnt(clr_cnt), .latch_state(ls_a), .PC_WEN(pc_a),
    .fsel_a(fa_a), .fsel_b(fb_a), .stall_cnt(st_a), .flush_cnt(fl_a)
  );

  hazard_ctrl #(.NLATCH(NLATCH), .NFWD(NFWD), .RW(RW), .FLUSH_CYC(3), .CNT_W(4)) u_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .redirect(redirect), .rs_dec(rs_dec), .rt_dec(rt_dec), .ex_wsel(ex_wsel),
    .ex_is_load(ex_is_load), .rs_ex(rs_ex), .rt_ex(rt_ex), .fwd_wsel(fwd_wsel),
    .fwd_wen(fwd_wen), .clr_cnt(clr_cnt), .latch_state(ls_b), .PC_WEN(pc_b),
    .fsel_a(fa_b), .fsel_b(fb_b), .stall_cnt(st_b), .flush_cnt(fl_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge, where inputs are driven
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // sample point for the current cycle
  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dREN = 1'b0; dWEN = 1'b0; redirect = 1'b0;
    ex_is_load = 1'b0; ex_wsel = '0; rs_dec = '0; rt_dec = '0; clr_cnt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    idle();
    rs_ex = 5'd7; rt_ex = 5'd7;
    fwd_wsel = {5'd7, 5'd7, 5'd7};
    fwd_wen  = 3'b111;

    // Reset state: outputs forced even with matching forwarding inputs
    nxt(); smp();
    chk("rst_latch", 32'(ls_a), 32'(ALL_NOP));
    chk("rst_pcwen", 32'(pc_a), 32'd0);
    chk("rst_fsel_a", 32'(fa_a), 32'd0);
    chk("rst_fsel_b", 32'(fb_b), 32'd0);
    chk("rst_stall", 32'(st_a), 32'd0);
    chk("rst_flush", 32'(fl_b), 32'd0);

    nxt(); RST = 1'b0; smp();
    chk("run_latch", 32'(ls_a), 32'(ALL_EN));
    chk("run_pcwen", 32'(pc_a), 32'd1);

    // Forwarding priority (combinational)
    chk("fwd_all_youngest", 32'(fa_a), 32'd1);
    rs_ex = 5'd0; #1;
    chk("fwd_r0_ignored", 32'(fa_a), 32'd0);
    rs_ex = 5'd7; fwd_wen = 3'b110; #1;
    chk("fwd_skip_disabled", 32'(fa_a), 32'd2);
    rt_ex = 5'd9; fwd_wsel = {5'd9, 5'd7, 5'd7}; fwd_wen = 3'b111; #1;
    chk("fwd_b_oldest", 32'(fb_b), 32'd3);
    chk("fwd_a_with_b", 32'(fa_b), 32'd1);
    rt_ex = 5'd4; #1;
    chk("fwd_b_nomatch", 32'(fb_a), 32'd0);

    // Load-use bubble
    nxt(); ex_is_load = 1'b1; ex_wsel = 5'd5; rs_dec = 5'd5; smp();
    chk("lu_latch", 32'(ls_a), 32'(LD_USE));
    chk("lu_pcwen", 32'(pc_a), 32'd0);
    nxt(); idle(); smp();
    chk("lu_after_latch", 32'(ls_a), 32'(ALL_EN));
    chk("lu_after_pcwen", 32'(pc_a), 32'd1);
    chk("lu_stall_cnt", 32'(st_a), 32'd1);
    // load into r0 never stalls
    nxt(); ex_is_load = 1'b1; ex_wsel = 5'd0; rs_dec = 5'd0; smp();
    chk("lu_r0_latch", 32'(ls_a), 32'(ALL_EN));

    // Dcache miss with redirect arriving during the wait
    nxt(); idle(); dREN = 1'b1; smp();
    chk("miss1_latch", 32'(ls_a), 32'(ALL_ST));
    chk("miss1_pcwen", 32'(pc_a), 32'd0);
    nxt(); redirect = 1'b1; smp();
    chk("miss2_latch", 32'(ls_a), 32'(ALL_ST));
    nxt(); redirect = 1'b0; smp();
    chk("miss3_latch", 32'(ls_b), 32'(ALL_ST));
    chk("miss3_pcwen", 32'(pc_b), 32'd0);
    nxt(); dhit = 1'b1; smp();
    chk("miss4_latch", 32'(ls_a), 32'(L01_NOP));
    chk("miss4_pcwen", 32'(pc_a), 32'd1);
    nxt(); idle(); smp();
    chk("miss_once_latch", 32'(ls_a), 32'(ALL_EN));
    chk("miss_flush_cnt", 32'(fl_a), 32'd1);
    chk("miss_stall_cnt", 32'(st_a), 32'd4);
    chk("miss_b_flushing", 32'(ls_b), 32'(L0_NOP));
    nxt(); smp();
    chk("miss_b_flush2", 32'(ls_b), 32'(L0_NOP));
    nxt(); smp();
    chk("miss_b_run", 32'(ls_b), 32'(ALL_EN));

    // Multi-cycle flush on u_b: two fetch-miss cycles then two hits
    nxt(); redirect = 1'b1; smp();
    chk("mf_redir_b", 32'(ls_b), 32'(L01_NOP));
    nxt(); redirect = 1'b0; ihit = 1'b0; smp();
    chk("mf_nohit1_b", 32'(ls_b), 32'(L0_NOP));
    chk("mf_nohit1_pc", 32'(pc_b), 32'd0);
    nxt(); smp();
    chk("mf_nohit2_b", 32'(ls_b), 32'(L0_NOP));
    nxt(); ihit = 1'b1; smp();
    chk("mf_hit1_b", 32'(ls_b), 32'(L0_NOP));
    chk("mf_hit1_pc", 32'(pc_b), 32'd1);
    chk("mf_hit1_a", 32'(ls_a), 32'(ALL_EN));
    nxt(); smp();
    chk("mf_hit2_b", 32'(ls_b), 32'(L0_NOP));
    nxt(); smp();
    chk("mf_done_b", 32'(ls_b), 32'(ALL_EN));
    chk("mf_flush_cnt_b", 32'(fl_b), 32'd2);
    chk("mf_stall_cnt_b", 32'(st_b), 32'd6);
    chk("mf_stall_cnt_a", 32'(st_a), 32'd6);

    // Saturation and clear
    for (int i = 0; i < 20; i++) begin
      nxt(); ihit = 1'b0;
    end
    nxt(); ihit = 1'b1; clr_cnt = 1'b1; smp();
    chk("sat_stall_b", 32'(st_b), 32'd15);
    chk("sat_stall_a", 32'(st_a), 32'd26);
    nxt(); clr_cnt = 1'b0; smp();
    chk("clr_stall_b", 32'(st_b), 32'd0);
    chk("clr_stall_a", 32'(st_a), 32'd0);
    chk("clr_flush_a", 32'(fl_a), 32'd0);

    // Reset in the middle of a dcache wait with a pending redirect
    nxt(); dREN = 1'b1; smp();
    nxt(); redirect = 1'b1; smp();
    nxt(); redirect = 1'b0; smp();
    chk("rw_wait_latch", 32'(ls_a), 32'(ALL_ST));
    #1 RST = 1'b1; #1;
    chk("rw_async_latch", 32'(ls_a), 32'(ALL_NOP));
    chk("rw_async_pcwen", 32'(pc_a), 32'd0);
    chk("rw_async_stall", 32'(st_a), 32'd0);
    nxt(); RST = 1'b0; dhit = 1'b1; smp();
    chk("rw_no_redir_a", 32'(ls_a), 32'(ALL_EN));
    chk("rw_no_redir_b", 32'(ls_b), 32'(ALL_EN));
    nxt(); idle(); smp();
    chk("rw_flush_cnt_a", 32'(fl_a), 32'd0);
    chk("rw_flush_cnt_b", 32'(fl_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
